word_mem_seq: RTL
=================

// Module: word_mem_seq
// PURPOSE
//  Load/store sequencer in front of the 64x8 byte data RAM. Accepts one 32-bit CPU
//  memory request (byte/half/word, load or store) and serialises it into 1/2/4
//  single-byte RAM accesses, one per clock. Returns assembled, sign/zero-extended
//  load data, or a misalignment error, as a one-cycle response pulse.
// PARAMETERS
//  ADDR_W   6   byte-address width; matches RAM depth 2**ADDR_W
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       reset, asynchronous, active-high
//  req_valid   in   1       request present
//  req_ready   out  1       sequencer can accept; request taken on valid&&ready edge
//  req_we      in   1       1=store, 0=load
//  req_size    in   2       00=byte, 01=half, 10=word, 11=reserved
//  req_signed  in   1       loads only: 1=sign-extend, 0=zero-extend
//  req_addr    in   ADDR_W  byte address of lowest byte
//  req_wdata   in   32      store data, right-justified
//  resp_valid  out  1       one-cycle pulse: request complete
//  resp_err    out  1       qualified by resp_valid: misaligned/reserved size
//  resp_rdata  out  32      qualified by resp_valid: load result (0 for stores/errors)
//  ram_a       out  ADDR_W  RAM byte address
//  ram_d       out  8       RAM write byte
//  ram_we      out  1       RAM write enable (RAM writes on posedge)
//  ram_re      out  1       RAM read enable (RAM read data is combinational)
//  ram_q       in   8       RAM read byte
// BEHAVIOUR
//  FSM: IDLE -> XFER -> DONE -> IDLE. Reset (async) forces IDLE, byte counter 0,
//   resp_valid=0, resp_err=0, resp_rdata=0, ram_we=0, ram_re=0, ram_a=0, ram_d=0.
//  IDLE: req_ready=1 (0 in every other state and while rst high). On valid&&ready
//   latch we/size/signed/addr/wdata; N = 1/2/4 for size 00/01/10.
//   Aligned (half: addr[0]=0; word: addr[1:0]=0) and size!=11 -> XFER, counter k=0.
//   Misaligned or size=11 -> DONE with err flag set; no RAM access at all.
//  XFER: one byte per cycle, k=0..N-1. ram_a = addr+k, little-endian: byte k of the
//   word occupies address addr+k. Store: ram_we=1, ram_d=wdata[8k+7:8k], ram_re=0.
//   Load: ram_re=1, ram_we=0; ram_q captured into rdata byte k at the cycle's edge.
//   After k=N-1 -> DONE. Alignment guarantees addr+k never wraps past 2**ADDR_W-1.
//  ram_* outputs decode from registered state/counter/latched request only; all 0
//   outside XFER. ram_we and ram_re never both 1.
//  DONE: resp_valid=1 for exactly this cycle, then IDLE. No response backpressure.
//   resp_rdata: load byte -> bits[7:0], upper filled with bit7 if signed else 0;
//   half -> bits[15:0], extend from bit15; word -> all 32 bits; store/err -> 0.
//  Latency: accept edge E0; bytes issued in cycles 1..N; resp_valid in cycle N+1;
//   req_ready high again in cycle N+2. Error: resp_valid in cycle 1.
//  Next request is accepted no earlier than the cycle after resp_valid; a request
//   held valid through busy cycles is accepted then, exactly once.
//  Reset mid-operation: abort immediately, no resp_valid; bytes already written stay
//   in RAM (no rollback); held request inputs are ignored until rst deasserts.
// TESTING
//  1 Store word 0xDEADBEEF @0x08 -> ram_we cycles 1-4, addrs 08..0B, d EF,BE,AD,DE;
//    resp_valid cycle 5, err=0, rdata=0.
//  2 Load word @0x08 after (1) -> ram_re 4 cycles, resp_rdata=0xDEADBEEF cycle 5.
//  3 Byte 0x80 @0x10: signed byte load -> 0xFFFFFF80; unsigned -> 0x00000080;
//    signed half @0x10 with 0x11 @0x11 -> 0x00001180.
//  4 Word @0x02, half @0x03, size=11 @0x00 -> resp_valid cycle 1, err=1, rdata=0,
//    ram_we/ram_re never asserted.
//  5 Word store @0x3C (top of RAM) -> addrs 3C..3F, no wrap; reload matches.
//  6 rst pulse mid word store after 2 bytes -> immediate IDLE, no resp_valid, only
//    bytes 0-1 changed; back-to-back held req_valid accepted once, cycle after resp.

Source files
------------

// File: rtl/word_mem_seq.sv
// rtl/word_mem_seq.sv - load/store sequencer serialising CPU requests onto a byte RAM
module word_mem_seq #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_d,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [7:0]        ram_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic                we_r;
  logic [1:0]          size_r;
  logic                sgn_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic [1:0]          k;
  logic                err_r;
  logic [31:0]         rdata_r;

  logic                accept;
  logic                bad_req;
  logic                last_byte;

  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Reserved size or an address not aligned to the access size is rejected up front.
  assign bad_req = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Counter value of the final byte for the latched access size.
  always_comb begin
    last_byte = 1'b0;
    case (size_r)
      2'b00:   last_byte = (k == 2'd0);
      2'b01:   last_byte = (k == 2'd1);
      default: last_byte = (k == 2'd3);
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = bad_req ? S_DONE : S_XFER;
      S_XFER: if (last_byte) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, byte counter and load-data assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      sgn_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'h0;
      k       <= 2'd0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0;
    end else begin
      if (accept) begin
        we_r    <= req_we;
        size_r  <= req_size;
        sgn_r   <= req_signed;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        k       <= 2'd0;
        err_r   <= bad_req;
        rdata_r <= 32'h0;
      end else if (state == S_XFER) begin
        k <= k + 2'd1;
        if (!we_r) rdata_r[8*k +: 8] <= ram_q;
      end
    end
  end

  // RAM port decode: driven only from registered state, quiet outside XFER.
  always_comb begin
    ram_a  = '0;
    ram_d  = 8'h00;
    ram_we = 1'b0;
    ram_re = 1'b0;
    if (state == S_XFER) begin
      ram_a = addr_r + {{(ADDR_W-2){1'b0}}, k};
      if (we_r) begin
        ram_we = 1'b1;
        ram_d  = wdata_r[8*k +: 8];
      end else begin
        ram_re = 1'b1;
      end
    end
  end

  // Response pulse with sign/zero extension of the assembled load data.
  always_comb begin
    resp_valid = (state == S_DONE);
    resp_err   = (state == S_DONE) && err_r;
    resp_rdata = 32'h0;
    if ((state == S_DONE) && !we_r && !err_r) begin
      case (size_r)
        2'b00:   resp_rdata = {{24{sgn_r & rdata_r[7]}}, rdata_r[7:0]};
        2'b01:   resp_rdata = {{16{sgn_r & rdata_r[15]}}, rdata_r[15:0]};
        default: resp_rdata = rdata_r;
      endcase
    end
  end

endmodule
